sm_convert_pipe: RTL

- Multi-lane, pipelined converter between two's-complement (2C) and sign-magnitude (SM) for the check-node datapath.
- Each beat carries N lanes of W-bit values plus a per-beat mode bit, and moves on a valid/ready handshake.
- 2C->SM saturates the most-negative code to maximum magnitude. SM->2C folds negative zero to 0.
- Keeps a saturating counter of saturation and negative-zero events for debug.

---
 rtl/sm_convert_pipe_pkg.sv | 9 +
 rtl/sm_lane_conv.sv | 21 ++
 rtl/sm_convert_pipe.sv | 65 ++++++
 3 files changed

// File: rtl/sm_convert_pipe_pkg.sv
// sm_convert_pipe_pkg: mode encodings and event-count helper shared by the converter pipe
package sm_convert_pipe_pkg;
  localparam logic MODE_2C2SM = 1'b0;
  localparam logic MODE_SM2C = 1'b1;
  function automatic logic [7:0] count_ones(input logic [31:0] v);
    count_ones = '0;
    for (int i = 0; i < 32; i++) count_ones += 8'(v[i]);
  endfunction
endpackage

// File: rtl/sm_lane_conv.sv
// sm_lane_conv: one-lane 2C<->SM conversion with saturation / negative-zero event flag
module sm_lane_conv
  import sm_convert_pipe_pkg::*;
#(
  parameter int W = 6
) (
  input  logic         mode,
  input  logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic         evt
);
  logic [W-2:0] m;
  logic [W-2:0] neg_m;
  logic         zero;
  assign m = x[W-2:0];
  assign neg_m = ~m + 1'b1;
  assign zero = m == '0;
  assign evt = x[W-1] & zero;
  // negating a nonzero magnitude is the same operation in both directions
  assign y = !x[W-1] ? x : !zero ? {1'b1, neg_m} : (mode == MODE_SM2C) ? '0 : '1;
endmodule

// File: rtl/sm_convert_pipe.sv
// sm_convert_pipe: two-stage valid/ready pipe converting N lanes between 2C and SM with event counter
module sm_convert_pipe
  import sm_convert_pipe_pkg::*;
#(
  parameter int W = 6,
  parameter int N = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [N*W-1:0]   in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mode,
  output logic [N*W-1:0]   out_data,
  input  logic             evt_clr,
  output logic [CNT_W-1:0] evt_count
);
  logic             s1_valid;
  logic             s1_mode;
  logic [N*W-1:0]   s1_data;
  logic [N*W-1:0]   conv_data;
  logic [N-1:0]     evt;
  logic             s2_adv;
  logic [CNT_W+7:0] sum;
  logic [CNT_W-1:0] cnt_nxt;
  for (genvar i = 0; i < N; i++) begin : g_lane
    sm_lane_conv #(.W(W)) u_conv (
      .mode(s1_mode),
      .x   (s1_data[i*W +: W]),
      .y   (conv_data[i*W +: W]),
      .evt (evt[i])
    );
  end
  assign s2_adv = s1_valid & (~out_valid | out_ready);
  assign in_ready = ~s1_valid | s2_adv;
  assign sum = (CNT_W+8)'(evt_count) + (CNT_W+8)'(count_ones(32'(evt)));
  assign cnt_nxt = (sum > (CNT_W+8)'({CNT_W{1'b1}})) ? '1 : sum[CNT_W-1:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_mode   <= 1'b0;
      s1_data   <= '0;
      out_valid <= 1'b0;
      out_mode  <= 1'b0;
      out_data  <= '0;
      evt_count <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_valid && in_ready) begin
        s1_data <= in_data;
        s1_mode <= in_mode;
      end
      if (s2_adv) begin
        out_valid <= 1'b1;
        out_data  <= conv_data;
        out_mode  <= s1_mode;
      end else if (out_ready) out_valid <= 1'b0;
      evt_count <= evt_clr ? '0 : s2_adv ? cnt_nxt : evt_count;
    end
  end
endmodule
